// File: rtl/carry_bypass_adder_pipe_if.sv
// Operand/result handshake bundle for carry_bypass_adder_pipe.
// The slave side is the adder. The master side is the producer/consumer pair.
interface carry_bypass_adder_pipe_if #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
);
  localparam int G = WIDTH / BLOCK;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic [G-1:0]     skip_mask;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, skip_mask
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, skip_mask
  );
endinterface

// File: rtl/carry_bypass_adder_pipe.sv
// Pipelined carry-bypass adder/subtractor. Each stage resolves one BLOCK-bit group.
// Whole-pipe stall on output backpressure. Async active-low reset.
module carry_bypass_adder_pipe #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input logic                      clk,
  input logic                      rst_n,
  carry_bypass_adder_pipe_if.slave bus
);
  localparam int G = WIDTH / BLOCK;

  generate
    if (BLOCK < 1 || BLOCK > WIDTH || (WIDTH % BLOCK) != 0) begin : g_param_check
      $error("carry_bypass_adder_pipe: WIDTH must be a positive multiple of BLOCK");
    end
  endgenerate

  // Rank 0 holds the accepted operands. Rank k+1 holds the state after group k resolves.
  logic             v_q     [0:G];
  logic [WIDTH-1:0] opa_q   [0:G-1];
  logic [WIDTH-1:0] opb_q   [0:G-1];
  logic [WIDTH-1:0] sum_q   [0:G];
  logic             carry_q [0:G];
  logic [G-1:0]     skip_q  [0:G];
  logic             cmsb_q;

  logic [WIDTH-1:0] sum_d   [1:G];
  logic             carry_d [1:G];
  logic [G-1:0]     skip_d  [1:G];
  logic             cmsb_d;

  logic [BLOCK-1:0] p;
  logic [BLOCK-1:0] gen;
  logic [BLOCK-1:0] s;
  logic             c;
  logic             cm;
  logic             adv;

  assign adv           = !v_q[G] || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = v_q[G];
  assign bus.sum       = sum_q[G];
  assign bus.cout      = carry_q[G];
  assign bus.ovf       = cmsb_q ^ carry_q[G];
  assign bus.skip_mask = skip_q[G];

  always_comb begin
    p      = '0;
    gen    = '0;
    s      = '0;
    c      = 1'b0;
    cm     = 1'b0;
    cmsb_d = 1'b0;
    for (int unsigned k = 0; k < G; k++) begin
      p   = opa_q[k][k*BLOCK +: BLOCK] ^ opb_q[k][k*BLOCK +: BLOCK];
      gen = opa_q[k][k*BLOCK +: BLOCK] & opb_q[k][k*BLOCK +: BLOCK];
      c   = carry_q[k];
      cm  = c;
      for (int unsigned i = 0; i < BLOCK; i++) begin
        cm   = c;
        s[i] = p[i] ^ c;
        c    = gen[i] | (p[i] & c);
      end
      sum_d[k+1]                    = sum_q[k];
      sum_d[k+1][k*BLOCK +: BLOCK]  = s;
      // A fully propagating group passes its carry-in straight through.
      carry_d[k+1]                  = (&p) ? carry_q[k] : c;
      skip_d[k+1]                   = skip_q[k];
      skip_d[k+1][k]                = &p;
      if (k == G - 1) cmsb_d = cm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r <= G; r++) begin
        v_q[r]     <= 1'b0;
        sum_q[r]   <= '0;
        carry_q[r] <= 1'b0;
        skip_q[r]  <= '0;
      end
      for (int unsigned r = 0; r < G; r++) begin
        opa_q[r] <= '0;
        opb_q[r] <= '0;
      end
      cmsb_q <= 1'b0;
    end else if (adv) begin
      v_q[0]     <= bus.in_valid;
      opa_q[0]   <= bus.a;
      opb_q[0]   <= bus.sub ? ~bus.b : bus.b;
      carry_q[0] <= bus.sub ^ bus.cin;
      sum_q[0]   <= '0;
      skip_q[0]  <= '0;
      for (int unsigned k = 0; k < G; k++) begin
        v_q[k+1]     <= v_q[k];
        sum_q[k+1]   <= sum_d[k+1];
        carry_q[k+1] <= carry_d[k+1];
        skip_q[k+1]  <= skip_d[k+1];
      end
      for (int unsigned k = 1; k < G; k++) begin
        opa_q[k] <= opa_q[k-1];
        opb_q[k] <= opb_q[k-1];
      end
      cmsb_q <= cmsb_d;
    end
  end
endmodule

// File: doc/carry_bypass_adder_pipe.md
# carry_bypass_adder_pipe

Parametrised, pipelined carry-bypass (carry-skip) adder/subtractor that succeeds the fixed 16-bit combinational carry-bypass adder. Operands are split into `G = WIDTH/BLOCK` groups. One group is resolved per pipeline stage, and each stage's carry-out uses the group-propagate bypass. The block sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. It sustains one operation per cycle, adds a subtract mode and a signed-overflow flag, and reports per-group bypass usage for verification.

## Interface
Parameters:
- `WIDTH`, 16, operand/result width; must be a multiple of `BLOCK` (otherwise elaboration error).
- `BLOCK`, 4, bits per bypass group; `1 <= BLOCK <= WIDTH`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  operand beat valid.
- `in_ready`  out  1  block can accept a beat this cycle.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `cin`  in  1  carry-in (add) / borrow-in (sub).
- `sub`  in  1  0: compute `a + b + cin`; 1: compute `a - b - cin`.
- `out_valid`  out  1  result beat valid.
- `out_ready`  in  1  consumer accepts the result.
- `sum`  out  WIDTH  result, modulo 2^WIDTH.
- `cout`  out  1  carry-out of the MSB; in sub mode, 1 means no borrow.
- `ovf`  out  1  two's-complement overflow.
- `skip_mask`  out  G  bit k = 1 when group k's carry-out was taken from the bypass path (group propagate all ones).

## Operation
- Accept: a beat is accepted when `in_valid && in_ready`.
- Input mapping:
  - Effective B operand: `bx = sub ? ~b : b`.
  - Carry into group 0: `c0 = sub ? ~cin : cin`.
- Stage k (k = 0..G-1) handles group k:
  - `p = a_k ^ bx_k`, `g = a_k & bx_k`.
  - Ripple the BLOCK bits from `c_k` to produce the group sum bits.
  - `c_{k+1} = (&p) ? c_k : ripple_carry_out`.
  - `skip_mask[k] = &p`.
- Pipeline registers carry, per stage:
  - the stage valid bit;
  - the unprocessed upper operand bits;
  - the completed lower sum bits;
  - the inter-group carry;
  - the accumulated `skip_mask` bits;
  - the carry into the MSB (captured in the last stage).
- Outputs:
  - `cout = c_G`.
  - `ovf = carry_into_msb ^ c_G`.
- Advance rule: `adv = !out_valid || out_ready`.
  - All stages shift only when `adv` = 1; otherwise every stage holds.
  - `in_ready = adv` (combinational).
- Bubbles: bubbles propagate as invalid stages. They are not compressed; a stall freezes the whole pipe.
- Ordering: results leave in acceptance order. No beat is dropped or duplicated.
- Subtract-mode result: `sum = a - b - cin` mod 2^WIDTH. `cout` = 0 iff the true result is negative.
- Degenerate cases:
  - `BLOCK = WIDTH`: one stage, skip applies to the whole word.
  - `BLOCK = 1`: `G = WIDTH` stages.

## Timing
- Reset values (rst_n low, asynchronous): `out_valid` 0, all stage valid bits 0, `sum` 0, `cout` 0, `ovf` 0, `skip_mask` 0.
- `in_ready` is 1 during and after reset, since `out_valid` = 0.
- Latency: a beat accepted at edge N presents `out_valid` = 1 after edge N+G, absent stalls. This is 4 cycles at the defaults.
- Throughput: 1 beat/cycle while `out_ready` = 1.
- Stalls: while `out_valid && !out_ready`, the outputs `sum`, `cout`, `ovf` and `skip_mask` stay stable and `in_ready` = 0.
- Simultaneous output handshake and input accept in the same cycle: both occur and the pipe shifts.
- Reset mid-operation: all in-flight beats are discarded immediately. No result is emitted after `rst_n` rises until a new beat completes G cycles after acceptance.
- `in_ready` and `out_valid` are functions of registered state and `out_ready` only. There is no combinational path from `in_valid` to `in_ready`.

## Test plan
Defaults WIDTH=16, BLOCK=4, latency 4 unless stated.
- Add with partial bypass: `a=0x00FF`, `b=0x0001`, `cin=0`, `sub=0` -> 4 cycles later `sum=0x0100`, `cout=0`, `ovf=0`, `skip_mask=4'b0010`.
- Full bypass chain: `a=0xFFFF`, `b=0x0000`, `cin=1` -> `sum=0x0000`, `cout=1`, `ovf=0`, `skip_mask=4'b1111`.
- Signed overflow: `a=0x7FFF`, `b=0x0001`, `cin=0` -> `sum=0x8000`, `cout=0`, `ovf=1`, `skip_mask=4'b0110`.
- Subtract with borrow: `a=0x0003`, `b=0x0005`, `cin=0`, `sub=1` -> `sum=0xFFFE`, `cout=0`, `ovf=0`.
- Backpressure and ordering:
  - Stimulus: 6 back-to-back random beats, with `out_ready` held low for 3 cycles after the first `out_valid`.
  - Required: `in_ready` low during the hold, output held stable, all 6 results correct and in order, none lost or duplicated.
  - Repeat the run at WIDTH=32, BLOCK=8 and at WIDTH=8, BLOCK=8 against a reference model.
- Reset mid-flight: 3 beats in flight, pulse `rst_n` low for 1 cycle -> `out_valid` drops asynchronously, none of the 3 results ever appear, and the next accepted beat emerges exactly 4 cycles after its acceptance.
